debug_unit: RTL
===============

Name: debug_unit

Overview:
Host-side control endpoint for the MIPS core: the initiator that drives the core's instruction-load port (write, instruction, address) and run-enable, and reads back PC and register-file contents through the debug-read port.
- Consumes a byte stream from the serial receiver: load program, run, single-step, dump.
- Produces a byte stream toward the serial transmitter.
- Sits between the UART and the core top level.

Parameters:
NB_ADDR, 32, width of instruction-memory address and PC
NB_INST, 32, instruction word width
NB_DATA, 32, register data width
NB_REG, 5, register index width
NB_BYTE, 8, serial byte width
N_REGS, 32, number of registers dumped

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  NB_BYTE  received byte
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
i_tx_ready  in  1  transmitter can accept a byte
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_valid  out  1  o_tx_data valid
o_write  out  1  instruction-memory write strobe
o_instruction  out  NB_INST  word to write
o_address  out  NB_ADDR  byte address of word to write
o_enable  out  1  core pipeline enable (run/step)
i_halt  in  1  core fetched/executed halt instruction
i_pc  in  NB_ADDR  current core PC
o_address_read_debug  out  NB_REG  register index for debug read
i_data_read_debug  in  NB_DATA  register data for o_address_read_debug, valid one cycle after address change
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, i_reset=1 at edge): state IDLE; all outputs 0; load address counter 0; byte counters 0. Reset in any state aborts the operation at once; no partial write is issued.
- States: IDLE, LOAD, WRITE, RUN, STEP, DUMP_ADDR, DUMP_WAIT, DUMP_TX.
- IDLE, command byte on i_rx_valid:
  - 0x4C 'L' -> LOAD; address counter cleared to 0.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x44 'D' -> DUMP_ADDR.
  - Any other byte is ignored; stay IDLE.
- LOAD:
  - Shifts in bytes MSB-first, 4 bytes per word, one per i_rx_valid pulse.
  - On the 4th byte -> WRITE.
- WRITE (exactly 1 cycle):
  - o_write=1, o_instruction=assembled word, o_address=counter.
  - Next cycle: o_write=0; counter += 4, wrapping modulo 2^NB_ADDR.
  - If the word was 0xFFFFFFFF (halt), it is still written, then -> IDLE; otherwise -> LOAD.
- RUN: o_enable=1 from the cycle after entry. On the first cycle i_halt=1 is sampled, o_enable=0 on the next cycle -> DUMP_ADDR.
- STEP: o_enable=1 for exactly one cycle -> DUMP_ADDR.
  - i_halt during STEP has no extra effect.
- Dump sequence: 4 PC bytes MSB-first, then for r = 0..N_REGS-1, 4 bytes of reg r MSB-first. Total 4 + 4*N_REGS bytes (132 by default).
  - PC is captured at DUMP_ADDR entry.
  - Per register: DUMP_ADDR drives o_address_read_debug=r, DUMP_WAIT holds 1 cycle, then i_data_read_debug is captured into a shift register for DUMP_TX.
  - After the last byte of reg N_REGS-1 -> IDLE; o_address_read_debug returns to 0.
- TX handshake:
  - o_tx_valid asserted with o_tx_data stable until the cycle with i_tx_ready=1; that cycle is the transfer.
  - Next byte is presented at the earliest on the following cycle.
  - Backpressure of any length is tolerated with no loss or duplication.
- Rx bytes arriving outside IDLE/LOAD, or during WRITE, are dropped.
- o_write and o_enable are never high in the same cycle.

Test Plan:
- Program load: send 'L', 0x20,0x01,0x00,0x05, 0x00,0x00,0x00,0x00, 0xFF,0xFF,0xFF,0xFF -> three o_write pulses with (addr,inst) = (0x0,0x20010005), (0x4,0x00000000), (0x8,0xFFFFFFFF); then IDLE with o_busy=0.
- Step + dump: model PC=0x4, reg r holds r*0x11; send 'S' -> o_enable high exactly 1 cycle; 132 bytes follow: 00 00 00 04, then 00 00 00 00, 00 00 00 11, ... ending with 00 00 02 0F.
- Run to halt: send 'R', raise i_halt after 10 cycles -> o_enable high for 10 cycles, low the cycle after i_halt, then 132-byte dump.
- Backpressure: during dump, toggle i_tx_ready randomly (and hold it low for 50 cycles) -> byte stream identical to the step+dump case; o_tx_data stable while o_tx_valid=1 and i_tx_ready=0.
- Unknown/stray bytes: 0x41 in IDLE -> no output change. Bytes sent during RUN -> ignored.
- Reset mid-load: reset after 2 data bytes -> no o_write, all outputs 0. A following load starts at address 0x0 with fresh byte alignment.

Source files
------------

// File: rtl/debug_unit.sv
// Host-side debug endpoint for the MIPS core: loads programs over the serial link,
// runs or single-steps the core, and streams PC plus the register file back out.
module debug_unit #(
    parameter int NB_ADDR = 32,
    parameter int NB_INST = 32,
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_BYTE = 8,
    parameter int N_REGS  = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_write,
    output logic [NB_INST-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_address,
    output logic               o_enable,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_pc,
    output logic [NB_REG-1:0]  o_address_read_debug,
    input  logic [NB_DATA-1:0] i_data_read_debug,
    output logic               o_busy
);

    localparam int BYTES_PER_WORD = NB_INST / NB_BYTE;
    localparam int NB_BCNT        = $clog2(BYTES_PER_WORD);

    localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'(8'h44);

    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
    localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGS - 1);
    localparam logic [NB_ADDR-1:0] WORD_STEP = NB_ADDR'(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RUN,
        STEP,
        DUMP_ADDR,
        DUMP_WAIT,
        DUMP_TX
    } state_t;

    state_t             state;
    logic [NB_INST-1:0] inst_shift;
    logic [NB_ADDR-1:0] addr_cnt;
    logic [NB_BCNT-1:0] byte_cnt;
    logic [NB_DATA-1:0] dump_shift;
    logic               pc_done;

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state                <= IDLE;
            inst_shift           <= '0;
            addr_cnt             <= '0;
            byte_cnt             <= '0;
            dump_shift           <= '0;
            pc_done              <= 1'b0;
            o_tx_data            <= '0;
            o_tx_valid           <= 1'b0;
            o_write              <= 1'b0;
            o_instruction        <= '0;
            o_address            <= '0;
            o_enable             <= 1'b0;
            o_address_read_debug <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        case (i_rx_data)
                            CMD_LOAD: begin
                                state    <= LOAD;
                                addr_cnt <= '0;
                                byte_cnt <= '0;
                            end
                            CMD_RUN: begin
                                state    <= RUN;
                                o_enable <= 1'b1;
                            end
                            CMD_STEP: begin
                                state    <= STEP;
                                o_enable <= 1'b1;
                            end
                            CMD_DUMP: begin
                                state                <= DUMP_ADDR;
                                dump_shift           <= NB_DATA'(i_pc);
                                pc_done              <= 1'b0;
                                o_address_read_debug <= '0;
                            end
                            default: ;
                        endcase
                    end
                end

                LOAD: begin
                    if (i_rx_valid) begin
                        inst_shift <= {inst_shift[NB_INST-NB_BYTE-1:0], i_rx_data};
                        byte_cnt   <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            state         <= WRITE;
                            o_write       <= 1'b1;
                            o_instruction <= {inst_shift[NB_INST-NB_BYTE-1:0], i_rx_data};
                            o_address     <= addr_cnt;
                        end
                    end
                end

                WRITE: begin
                    o_write  <= 1'b0;
                    addr_cnt <= addr_cnt + WORD_STEP;
                    byte_cnt <= '0;
                    state    <= (o_instruction == '1) ? IDLE : LOAD;
                end

                RUN: begin
                    if (i_halt) begin
                        o_enable             <= 1'b0;
                        state                <= DUMP_ADDR;
                        dump_shift           <= NB_DATA'(i_pc);
                        pc_done              <= 1'b0;
                        o_address_read_debug <= '0;
                    end
                end

                STEP: begin
                    o_enable             <= 1'b0;
                    state                <= DUMP_ADDR;
                    dump_shift           <= NB_DATA'(i_pc);
                    pc_done              <= 1'b0;
                    o_address_read_debug <= '0;
                end

                DUMP_ADDR: state <= DUMP_WAIT;

                // The PC word was preloaded at dump entry; register words arrive here.
                DUMP_WAIT: begin
                    if (pc_done) begin
                        dump_shift <= i_data_read_debug;
                        o_tx_data  <= i_data_read_debug[NB_DATA-1 -: NB_BYTE];
                    end else begin
                        o_tx_data  <= dump_shift[NB_DATA-1 -: NB_BYTE];
                    end
                    o_tx_valid <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= DUMP_TX;
                end

                DUMP_TX: begin
                    if (i_tx_ready) begin
                        byte_cnt   <= byte_cnt + 1'b1;
                        dump_shift <= dump_shift << NB_BYTE;
                        o_tx_data  <= dump_shift[NB_DATA-NB_BYTE-1 -: NB_BYTE];
                        if (byte_cnt == LAST_BYTE) begin
                            o_tx_valid <= 1'b0;
                            if (!pc_done) begin
                                pc_done <= 1'b1;
                                state   <= DUMP_ADDR;
                            end else if (o_address_read_debug == LAST_REG) begin
                                o_address_read_debug <= '0;
                                state                <= IDLE;
                            end else begin
                                o_address_read_debug <= o_address_read_debug + 1'b1;
                                state                <= DUMP_ADDR;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
